ipu_frame_sequencer: RTL and testbench



---
 rtl/ipu_frame_sequencer_pkg.sv | 38 +++
 rtl/ipu_frame_sequencer_row_loader.sv | 53 +++++
 rtl/ipu_frame_sequencer.sv | 175 +++++++++++++++++
 tb/tb_ipu_frame_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipu_frame_sequencer_pkg.sv
// Shared types for the IPU frame sequencer: FSM states, coprocessor opcodes
// and the conv_inst field layout.
package ipu_frame_sequencer_pkg;

   localparam int unsigned INST_W   = 32;
   localparam int unsigned OPCODE_W = 4;
   localparam int unsigned FILTER_W = 3;
   localparam int unsigned KSIZE_W  = 2;
   localparam int unsigned ROWS_W   = 3;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ISSUE   = 3'd2,
      S_WAIT    = 3'd3,
      S_ROW_GAP = 3'd4
   } seq_state_e;

   typedef enum logic [OPCODE_W-1:0] {
      OP_CONV       = 4'b0101,
      OP_CONV_TRSP  = 4'b0110,
      OP_CONV_ROB   = 4'b0111,
      OP_B2G        = 4'b1000,
      OP_PHOTO_CONV = 4'b1110,
      OP_READ_IMAGE = 4'b1111
   } conv_opcode_e;

   // conv_inst = {zero pad, v[cnt_w-1:0], h[cnt_w-1:0], opcode[3:0]}
   function automatic logic [INST_W-1:0] conv_inst_pack(
      input logic [15:0]         v,
      input logic [15:0]         h,
      input logic [OPCODE_W-1:0] op,
      input int unsigned         cnt_w
   );
      return (INST_W'(v) << (cnt_w + OPCODE_W)) | (INST_W'(h) << OPCODE_W) | INST_W'(op);
   endfunction

endpackage

// File: rtl/ipu_frame_sequencer_row_loader.sv
// Line-buffer load counter: walks buf_h across a row in word steps, bumps buf_v
// at each row end and counts down the rows still to load.
module ipu_row_loader
   import ipu_frame_sequencer_pkg::*;
#(
   parameter int unsigned IMG_W        = 512,
   parameter int unsigned PIX_PER_WORD = 4,
   parameter int unsigned CNT_W        = 9
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              frame_start,
   input  logic              row_gap,
   input  logic              load_en,
   input  logic [ROWS_W-1:0] rows_init,
   output logic [CNT_W-1:0]  buf_h,
   output logic [CNT_W-1:0]  buf_v,
   output logic              row_done
);

   localparam logic [CNT_W-1:0] LAST_H   = CNT_W'(IMG_W - PIX_PER_WORD);
   localparam logic [CNT_W-1:0] PPW_STEP = CNT_W'(PIX_PER_WORD);

   logic [ROWS_W-1:0] rows_left;
   logic              row_end;

   assign row_end  = (buf_h == LAST_H);
   // Final word of the final row; only meaningful to the FSM while loading.
   assign row_done = row_end && (rows_left == '0);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         buf_h     <= '0;
         buf_v     <= '0;
         rows_left <= '0;
      end else if (frame_start) begin
         buf_h     <= '0;
         buf_v     <= '0;
         rows_left <= rows_init;
      end else if (row_gap) begin
         rows_left <= '0;
      end else if (load_en) begin
         if (row_end) begin
            buf_h <= '0;
            buf_v <= buf_v + CNT_W'(1);
            if (rows_left != '0) rows_left <= rows_left - ROWS_W'(1);
         end else begin
            buf_h <= buf_h + PPW_STEP;
         end
      end
   end

endmodule

// File: rtl/ipu_frame_sequencer.sv
// Frame sequencer: preloads the line buffer, then issues one coprocessor
// request per pixel, reloading one row between output rows.
module ipu_frame_sequencer
   import ipu_frame_sequencer_pkg::*;
#(
   parameter int unsigned IMG_W        = 512,
   parameter int unsigned IMG_H        = 480,
   parameter int unsigned PIX_PER_WORD = 4,
   parameter int unsigned CNT_W        = 9,
   parameter int unsigned ADDR_W       = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [FILTER_W-1:0] filter_code,
   input  logic [KSIZE_W-1:0]  ksize,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                conv_wait,
   input  logic                conv_done,
   output logic                busy,
   output logic                frame_done,
   output logic                aborted,
   output logic [FILTER_W-1:0] filter_sel,
   output logic                buf_start,
   output logic                buf_next,
   output logic [CNT_W-1:0]    buf_h,
   output logic [CNT_W-1:0]    buf_v,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                conv_req,
   output logic [INST_W-1:0]   conv_inst
);

   localparam int unsigned      PPW_LOG = $clog2(PIX_PER_WORD);
   localparam int unsigned      RAW_W   = 2 * CNT_W - PPW_LOG;
   localparam logic [CNT_W-1:0] H_MAX   = CNT_W'(IMG_W - 1);
   localparam logic [CNT_W-1:0] V_MAX   = CNT_W'(IMG_H - 1);

   seq_state_e          state, state_n;
   logic [CNT_W-1:0]    h_conv, h_conv_n, v_conv, v_conv_n;
   logic [FILTER_W-1:0] filter_sel_n;
   logic [INST_W-1:0]   conv_inst_n;
   logic                conv_req_n, buf_start_n, buf_next_n, frame_done_n, aborted_n;
   logic                frame_start, row_gap, load_en, row_done;
   logic [RAW_W-1:0]    addr_raw;

   ipu_row_loader #(
      .IMG_W        (IMG_W),
      .PIX_PER_WORD (PIX_PER_WORD),
      .CNT_W        (CNT_W)
   ) u_row_loader (
      .clk         (clk),
      .reset_n     (reset_n),
      .frame_start (frame_start),
      .row_gap     (row_gap),
      .load_en     (load_en),
      .rows_init   (ROWS_W'(ksize) + ROWS_W'(1)),
      .buf_h       (buf_h),
      .buf_v       (buf_v),
      .row_done    (row_done)
   );

   // Word address is pure wiring of the registered load coordinates.
   assign addr_raw = {buf_v, buf_h[CNT_W-1:PPW_LOG]};
   assign mem_addr = ADDR_W'(addr_raw);

   always_comb begin
      state_n      = state;
      filter_sel_n = filter_sel;
      conv_req_n   = conv_req;
      conv_inst_n  = conv_inst;
      buf_start_n  = buf_start;
      buf_next_n   = 1'b0;
      frame_done_n = 1'b0;
      aborted_n    = 1'b0;
      h_conv_n     = h_conv;
      v_conv_n     = v_conv;
      frame_start  = 1'b0;
      row_gap      = 1'b0;
      load_en      = 1'b0;

      // Abort outranks everything, including a conv_done in the same cycle.
      if (state != S_IDLE && abort) begin
         state_n     = S_IDLE;
         conv_req_n  = 1'b0;
         buf_start_n = 1'b0;
         aborted_n   = 1'b1;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  filter_sel_n = filter_code;
                  frame_start  = 1'b1;
                  h_conv_n     = '0;
                  v_conv_n     = '0;
                  buf_start_n  = 1'b1;
                  state_n      = S_LOAD;
               end
            end
            S_LOAD: begin
               load_en = 1'b1;
               if (row_done) begin
                  buf_start_n = 1'b0;
                  state_n     = S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (!conv_wait) begin
                  conv_req_n  = 1'b1;
                  conv_inst_n = conv_inst_pack(16'(v_conv), 16'(h_conv), opcode, CNT_W);
                  state_n     = S_WAIT;
               end
            end
            S_WAIT: begin
               if (conv_done) begin
                  conv_req_n = 1'b0;
                  buf_next_n = 1'b1;
                  if (h_conv == H_MAX) begin
                     h_conv_n = '0;
                     if (v_conv == V_MAX) begin
                        frame_done_n = 1'b1;
                        state_n      = S_IDLE;
                     end else begin
                        v_conv_n = v_conv + CNT_W'(1);
                        state_n  = S_ROW_GAP;
                     end
                  end else begin
                     h_conv_n = h_conv + CNT_W'(1);
                     state_n  = S_ISSUE;
                  end
               end
            end
            S_ROW_GAP: begin
               row_gap     = 1'b1;
               buf_start_n = 1'b1;
               state_n     = S_LOAD;
            end
            default: begin
               state_n     = S_IDLE;
               conv_req_n  = 1'b0;
               buf_start_n = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         aborted    <= 1'b0;
         filter_sel <= '0;
         buf_start  <= 1'b0;
         buf_next   <= 1'b0;
         conv_req   <= 1'b0;
         conv_inst  <= '0;
         h_conv     <= '0;
         v_conv     <= '0;
      end else begin
         state      <= state_n;
         busy       <= (state_n != S_IDLE);
         frame_done <= frame_done_n;
         aborted    <= aborted_n;
         filter_sel <= filter_sel_n;
         buf_start  <= buf_start_n;
         buf_next   <= buf_next_n;
         conv_req   <= conv_req_n;
         conv_inst  <= conv_inst_n;
         h_conv     <= h_conv_n;
         v_conv     <= v_conv_n;
      end
   end

endmodule

// File: tb/tb_ipu_frame_sequencer.sv
// Self-checking bench for ipu_frame_sequencer on a small 8x3 frame, with a
// coprocessor responder and a queue-based model of the expected request order.
module tb_ipu_frame_sequencer;

   localparam int IMG_W      = 8;
   localparam int IMG_H      = 3;
   localparam int PPW        = 4;
   localparam int CNT_W      = 9;
   localparam int ADDR_W     = 16;
   localparam int WORDS      = IMG_W / PPW;
   localparam int ROW_STRIDE = 1 << (CNT_W - 2);

   logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
   logic conv_wait = 1'b0, conv_done = 1'b0;
   logic [2:0] filter_code = '0;
   logic [1:0] ksize = '0;
   logic [3:0] opcode = '0;
   logic busy, frame_done, aborted, buf_start, buf_next, conv_req;
   logic [2:0] filter_sel;
   logic [CNT_W-1:0] buf_h, buf_v;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0] conv_inst;

   int total = 0, bad = 0;
   bit auto_done = 1'b0, rand_lat = 1'b0;
   int age = 0, lat = 2;

   always #5 clk = ~clk;

   ipu_frame_sequencer #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_PER_WORD(PPW), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .filter_code(filter_code), .ksize(ksize), .opcode(opcode),
      .conv_wait(conv_wait), .conv_done(conv_done), .busy(busy),
      .frame_done(frame_done), .aborted(aborted), .filter_sel(filter_sel),
      .buf_start(buf_start), .buf_next(buf_next), .buf_h(buf_h), .buf_v(buf_v),
      .mem_addr(mem_addr), .conv_req(conv_req), .conv_inst(conv_inst)
   );

   // Coprocessor: conv_done for one cycle, lat cycles after conv_req rises.
   initial forever begin
      @(negedge clk);
      if (auto_done) begin
         if (conv_done) begin
            conv_done = 1'b0;
            age = 0;
            lat = rand_lat ? int'($urandom_range(0, 3)) : 2;
         end else if (conv_req) begin
            age++;
            if (age > lat) conv_done = 1'b1;
         end else begin
            age = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [74:0] all_out;
      reset_n = 1'b0;
      tick(); tick();
      all_out = {busy, frame_done, aborted, filter_sel, buf_start, buf_next,
                 buf_h, buf_v, mem_addr, conv_req, conv_inst};
      total++;
      if (all_out !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", all_out); end
      reset_n = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b want=0", busy); end
   endtask

   task automatic test_abort_idle();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if ({busy, aborted} !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b want=00", {busy, aborted}); end
   endtask

   // Runs one whole frame and checks it against the model built up front.
   task automatic run_frame(input bit rnd, input logic [3:0] op, input logic [2:0] fc,
                            input logic [1:0] ks, input bit hold_start);
      logic [31:0] exp_q[$];
      int addr_q[$];
      logic [31:0] e;
      int n_req = 0, n_next = 0, n_fd = 0, cyc = 0, t_done = -1, gap = 0, run = 0, a;
      bit first_load = 1'b1, prev_req = 1'b0, prev_wait = 1'b0, fin = 1'b0;
      for (int v = 0; v < IMG_H; v++)
         for (int h = 0; h < IMG_W; h++)
            exp_q.push_back((32'(v) << (CNT_W + 4)) | (32'(h) << 4) | 32'(op));
      for (int r = 0; r < int'(ks) + 2; r++)
         for (int w = 0; w < WORDS; w++)
            addr_q.push_back(r * ROW_STRIDE + w);
      opcode = op; filter_code = fc; ksize = ks; conv_wait = 1'b0;
      rand_lat = rnd; auto_done = 1'b1; start = 1'b1;
      tick();
      if (!hold_start) start = 1'b0;
      while (!fin && cyc < 3000) begin
         if (first_load) begin
            if (buf_start) begin
               total++;
               if (addr_q.size() == 0) begin
                  bad++; $display("FAIL load_addr_extra got=%0d want=none", mem_addr);
               end else begin
                  a = addr_q.pop_front();
                  if (int'(mem_addr) != a) begin bad++; $display("FAIL load_addr got=%0d want=%0d", mem_addr, a); end
               end
            end else begin
               first_load = 1'b0;
               total++;
               if (addr_q.size() != 0) begin bad++; $display("FAIL load_addr_count got_left=%0d want=0", addr_q.size()); end
            end
         end else if (buf_start) begin
            run++;
         end else if (run > 0) begin
            total++;
            if (run != WORDS) begin bad++; $display("FAIL row_gap_load_len got=%0d want=%0d", run, WORDS); end
            run = 0;
         end
         if (conv_req && !prev_req) begin
            n_req++;
            total++;
            if (prev_wait) begin bad++; $display("FAIL req_during_wait got=1 want=0"); end
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL req_extra got=%h want=none", conv_inst);
            end else begin
               e = exp_q.pop_front();
               if (conv_inst !== e) begin bad++; $display("FAIL conv_inst got=%h want=%h", conv_inst, e); end
            end
            if (!rnd && t_done >= 0) begin
               total++;
               if (cyc - t_done != gap) begin bad++; $display("FAIL req_latency got=%0d want=%0d", cyc - t_done, gap); end
            end
         end
         if (conv_req && conv_done) begin
            t_done = cyc;
            gap = ((n_req - 1) % IMG_W == IMG_W - 1) ? 3 + WORDS : 2;
         end
         if (buf_next) n_next++;
         if (frame_done) begin
            n_fd++; fin = 1'b1;
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%b want=0", busy); end
         end
         prev_req = conv_req;
         conv_wait = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
         prev_wait = conv_wait;
         tick();
         cyc++;
      end
      auto_done = 1'b0; conv_done = 1'b0; conv_wait = 1'b0;
      total++;
      if (n_fd != 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", n_fd); end
      total++;
      if (n_req != IMG_W * IMG_H) begin bad++; $display("FAIL req_count got=%0d want=%0d", n_req, IMG_W * IMG_H); end
      total++;
      if (n_next != IMG_W * IMG_H) begin bad++; $display("FAIL buf_next_count got=%0d want=%0d", n_next, IMG_W * IMG_H); end
      total++;
      if (filter_sel !== fc) begin bad++; $display("FAIL filter_sel got=%0d want=%0d", filter_sel, fc); end
      total++;
      if ({frame_done, busy} !== {1'b0, hold_start}) begin
         bad++; $display("FAIL after_done got=%b want=%b", {frame_done, busy}, {1'b0, hold_start});
      end
   endtask

   task automatic test_basic_frame();
      run_frame(1'b0, 4'b0101, 3'd5, 2'd1, 1'b0);
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL basic_idle_busy got=%b want=0", busy); end
   endtask

   task automatic test_conv_wait();
      int n = 0;
      opcode = 4'b0110; filter_code = 3'd1; ksize = 2'd0; conv_wait = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      while (buf_start && n < 50) begin tick(); n++; end
      total++;
      if (buf_start !== 1'b0) begin bad++; $display("FAIL wait_load_timeout got=%b want=0", buf_start); end
      for (int i = 0; i < 6; i++) begin
         total++;
         if (conv_req !== 1'b0) begin bad++; $display("FAIL req_held_by_wait cyc=%0d got=%b want=0", i, conv_req); end
         if (i < 5) tick();
      end
      conv_wait = 1'b0;
      tick();
      total++;
      if ({conv_req, conv_inst} !== {1'b1, 32'h6}) begin
         bad++; $display("FAIL req_after_wait got=%b/%h want=1/00000006", conv_req, conv_inst);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if ({aborted, busy, conv_req} !== 3'b100) begin bad++; $display("FAIL abort_issue got=%b want=100", {aborted, busy, conv_req}); end
      tick();
      total++;
      if (aborted !== 1'b0) begin bad++; $display("FAIL aborted_pulse got=%b want=0", aborted); end
   endtask

   task automatic test_abort_with_done();
      int n = 0;
      opcode = 4'b0101; ksize = 2'd0; conv_wait = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      while (!conv_req && n < 50) begin tick(); n++; end
      total++;
      if (conv_req !== 1'b1) begin bad++; $display("FAIL abort_wait_req_timeout got=%b want=1", conv_req); end
      abort = 1'b1; conv_done = 1'b1;
      tick();
      abort = 1'b0; conv_done = 1'b0;
      total++;
      if ({aborted, buf_next, frame_done, busy, conv_req, buf_start} !== 6'b100000) begin
         bad++; $display("FAIL abort_done got=%b want=100000", {aborted, buf_next, frame_done, busy, conv_req, buf_start});
      end
      tick();
      total++;
      if ({aborted, frame_done, busy} !== 3'b000) begin bad++; $display("FAIL abort_after got=%b want=000", {aborted, frame_done, busy}); end
   endtask

   task automatic test_reset_mid_load();
      logic [74:0] all_out;
      ksize = 2'd2; filter_code = 3'd6; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      all_out = {busy, frame_done, aborted, filter_sel, buf_start, buf_next,
                 buf_h, buf_v, mem_addr, conv_req, conv_inst};
      total++;
      if (all_out !== '0) begin bad++; $display("FAIL reset_mid_load got=%h want=0", all_out); end
      reset_n = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({buf_start, busy, buf_h, buf_v} !== {2'b11, 18'd0}) begin
         bad++; $display("FAIL restart_after_reset got=%b/%b/%0d/%0d want=1/1/0/0", buf_start, busy, buf_h, buf_v);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
   endtask

   task automatic test_start_held();
      run_frame(1'b0, 4'b1000, 3'd7, 2'd1, 1'b1);
      total++;
      if ({buf_start, buf_h, buf_v, aborted} !== {1'b1, 18'd0, 1'b0}) begin
         bad++; $display("FAIL held_restart got=%b/%0d/%0d/%b want=1/0/0/0", buf_start, buf_h, buf_v, aborted);
      end
      start = 1'b0;
      tick();
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL held_busy got=%b want=1", busy); end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL held_single_frame got=%b want=0", busy); end
   endtask

   task automatic test_random();
      for (int k = 0; k < 4; k++)
         run_frame(1'b1, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), 1'b0);
   endtask

   initial begin
      test_reset();
      test_abort_idle();
      test_basic_frame();
      test_conv_wait();
      test_abort_with_done();
      test_reset_mid_load();
      test_start_held();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
